axi4l_regbank: RTL and testbench

- Synthesizable AXI4-Lite slave register bank: NUM_REGS registers of DATA_WIDTH bits, exposed to fabric logic.
- Read/write, per-register read-only masking, byte strobes and full SLVERR/DECERR response generation.
- Sits behind any AXI4-Lite master (interconnect or the axi4l_pkg driver). It is the RTL counterpart to the verification-side transaction/driver.

---
 rtl/axi4l_pkg.sv | 49 ++++
 rtl/axi4l_wr_ctrl.sv | 125 ++++++++++++
 rtl/axi4l_regbank.sv | 179 +++++++++++++++++
 tb/tb_axi4l_regbank.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types: response codes, register-bank FSM states and the
// address decode helper used by both the write controller and the read path.
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi4l_resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } axi4l_wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } axi4l_rd_state_t;

    // Upper bound on register count; read-only masks are widened to this size
    // so one decode function serves every bank configuration.
    localparam int unsigned AXI4L_MAX_REGS = 4096;

    typedef struct packed {
        logic [31:0] idx;
        axi4l_resp_t resp;
    } axi4l_dec_t;

    // Classify a word index: out of range -> DECERR, write to a read-only
    // slot -> SLVERR, anything else -> OKAY.
    function automatic axi4l_dec_t axi4l_decode(
        input logic [31:0]               idx,
        input int unsigned               num_regs,
        input logic [AXI4L_MAX_REGS-1:0] ro_mask,
        input logic                      is_wr
    );
        axi4l_dec_t d;
        d.idx  = idx;
        d.resp = OKAY;
        if (idx >= num_regs)
            d.resp = DECERR;
        else if (is_wr && ro_mask[idx[11:0]])
            d.resp = SLVERR;
        return d;
    endfunction

endpackage

// File: rtl/axi4l_wr_ctrl.sv
// AXI4-Lite write channel controller: captures AW and W independently, raises
// a commit strobe on the edge where both are available, and drives the B
// channel until the master accepts the response.
module axi4l_wr_ctrl
    import axi4l_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 12,
    parameter int unsigned          NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    output logic                    o_commit,
    output logic [31:0]             o_idx,
    output logic [1:0]              o_resp,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb
);

    localparam int unsigned LSB = $clog2(DATA_WIDTH/8);
    localparam logic [AXI4L_MAX_REGS-1:0] RO_EXT = AXI4L_MAX_REGS'(RO_MASK);

    axi4l_wr_state_t           r_state, w_next;
    logic                      r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0]     r_awaddr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH/8-1:0]   r_wstrb;
    axi4l_resp_t               r_bresp;

    logic                      w_commit, w_aw_hs, w_w_hs;
    logic [ADDR_WIDTH-1:0]     w_awaddr;
    logic [DATA_WIDTH-1:0]     w_wdata;
    logic [DATA_WIDTH/8-1:0]   w_wstrb;
    axi4l_dec_t                w_dec;
    logic                      w_unused_lsb;

    // A captured beat takes precedence over the live bus for the commit.
    assign w_awaddr = r_aw_held ? r_awaddr : i_awaddr;
    assign w_wdata  = r_w_held  ? r_wdata  : i_wdata;
    assign w_wstrb  = r_w_held  ? r_wstrb  : i_wstrb;
    assign w_dec    = axi4l_decode(32'(w_awaddr[ADDR_WIDTH-1:LSB]), NUM_REGS, RO_EXT, 1'b1);
    assign w_aw_hs  = i_awvalid && o_awready;
    assign w_w_hs   = i_wvalid && o_wready;
    assign w_unused_lsb = ^w_awaddr[LSB-1:0];

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= W_IDLE;
        else        r_state <= w_next;
    end

    // Next state, ready/valid and commit decision; a channel that is not yet
    // held is ready, so its valid alone means it handshakes this edge.
    always_comb begin
        w_next    = r_state;
        o_awready = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            W_IDLE: begin
                o_awready = rst_n && !r_aw_held;
                o_wready  = rst_n && !r_w_held;
                if (rst_n && (r_aw_held || i_awvalid) && (r_w_held || i_wvalid)) begin
                    w_commit = 1'b1;
                    w_next   = W_RESP;
                end
            end
            W_RESP: begin
                o_bvalid = 1'b1;
                if (i_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Hold an early AW or W beat until its partner arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= i_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
            end
        end
    end

    // Latch the response code alongside the commit for the B channel.
    always_ff @(posedge clk) begin
        if (!rst_n)        r_bresp <= OKAY;
        else if (w_commit) r_bresp <= w_dec.resp;
    end

    assign o_bresp  = r_bresp;
    assign o_commit = w_commit;
    assign o_idx    = w_dec.idx;
    assign o_resp   = w_dec.resp;
    assign o_wdata  = w_wdata;
    assign o_wstrb  = w_wstrb;

endmodule

// File: rtl/axi4l_regbank.sv
// AXI4-Lite slave register bank. Holds the register array and read path; the
// write handshake lives in axi4l_wr_ctrl. Read-only slots mirror reg_in.
// Optional feature: define AXI4L_REGBANK_WSTRB_EN to honour byte strobes;
// without it every write replaces the full word.
module axi4l_regbank
    import axi4l_pkg::*;
#(
    parameter int unsigned                        DATA_WIDTH = 32,
    parameter int unsigned                        ADDR_WIDTH = 12,
    parameter int unsigned                        NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0]                RO_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]     RST_VAL    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]            wr_pulse,
    output logic [NUM_REGS-1:0]            rd_pulse
);

    localparam int unsigned STRB_W = DATA_WIDTH/8;
    localparam int unsigned LSB    = $clog2(STRB_W);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] r_regs;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] w_view;
    logic [NUM_REGS-1:0]                 r_wr_pulse, r_rd_pulse;
    logic [DATA_WIDTH-1:0]               r_rdata;
    axi4l_resp_t                         r_rresp;
    axi4l_rd_state_t                     r_rstate, w_rnext;

    logic                                w_commit;
    logic [31:0]                         w_widx;
    logic [1:0]                          w_wresp;
    logic [DATA_WIDTH-1:0]               w_wdata;
    logic [STRB_W-1:0]                   w_wstrb, w_bmask;
    logic                                w_wr_ok;
    axi4l_dec_t                          w_rdec;
    logic [DATA_WIDTH-1:0]               w_rsel;
    logic                                w_ar_hs;
    logic                                w_unused;

    axi4l_wr_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_wr_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_awaddr  (s_awaddr),
        .i_awvalid (s_awvalid),
        .o_awready (s_awready),
        .i_wdata   (s_wdata),
        .i_wstrb   (s_wstrb),
        .i_wvalid  (s_wvalid),
        .o_wready  (s_wready),
        .o_bresp   (s_bresp),
        .o_bvalid  (s_bvalid),
        .i_bready  (s_bready),
        .o_commit  (w_commit),
        .o_idx     (w_widx),
        .o_resp    (w_wresp),
        .o_wdata   (w_wdata),
        .o_wstrb   (w_wstrb)
    );

`ifdef AXI4L_REGBANK_WSTRB_EN
    assign w_bmask = w_wstrb;
`else
    assign w_bmask = '1;
`endif

    assign w_wr_ok  = w_commit && (w_wresp == OKAY);
    assign w_unused = ^{s_araddr[LSB-1:0], reg_in, r_regs, w_wstrb};

    // Register array: reset image, then byte-masked updates on a clean commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regs <= RST_VAL;
        end else if (w_wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < STRB_W; b++)
                    if (w_widx == 32'(i) && w_bmask[b])
                        r_regs[i][b*8 +: 8] <= w_wdata[b*8 +: 8];
        end
    end

    // Visible register image: read-only slots come straight from reg_in.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
        if (RO_MASK[i]) begin : g_ro
            assign w_view[i] = reg_in[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_rw
            assign w_view[i] = r_regs[i];
        end
    end
    assign reg_out = w_view;

    assign w_rdec  = axi4l_decode(32'(s_araddr[ADDR_WIDTH-1:LSB]), NUM_REGS, '0, 1'b0);
    assign w_ar_hs = s_arvalid && s_arready;

    // Read mux over the pre-edge image so a same-cycle write is not visible.
    always_comb begin
        w_rsel = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (w_rdec.idx == 32'(i)) w_rsel = w_view[i];
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_rstate <= R_IDLE;
        else        r_rstate <= w_rnext;
    end

    // Read FSM next state and AR/R handshake signals.
    always_comb begin
        w_rnext   = r_rstate;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s_arready = rst_n;
                if (rst_n && s_arvalid) w_rnext = R_DATA;
            end
            R_DATA: begin
                s_rvalid = 1'b1;
                if (s_rready) w_rnext = R_IDLE;
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    // Read payload captured at accept and held until the master takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_rresp <= OKAY;
        end else if (w_ar_hs) begin
            r_rdata <= (w_rdec.resp == DECERR) ? '0 : w_rsel;
            r_rresp <= w_rdec.resp;
        end
    end

    // One-cycle strobes for a clean write commit and an in-range read accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_pulse <= '0;
            r_rd_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_wr_pulse[i] <= w_wr_ok && (w_widx == 32'(i));
                r_rd_pulse[i] <= w_ar_hs && (w_rdec.resp == OKAY) && (w_rdec.idx == 32'(i));
            end
        end
    end

    assign s_rdata  = r_rdata;
    assign s_rresp  = r_rresp;
    assign wr_pulse = r_wr_pulse;
    assign rd_pulse = r_rd_pulse;

endmodule

// File: tb/tb_axi4l_regbank.sv
// Directed bench for axi4l_regbank with a response scoreboard.
module tb_axi4l_regbank;
    import axi4l_pkg::*;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NR = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [AW-1:0]  awaddr, araddr;
    logic           awvalid, wvalid, bready, arvalid, rready;
    logic [DW-1:0]  wdata;
    logic [3:0]     wstrb;
    logic           awready, wready, bvalid, arready, rvalid;
    logic [1:0]     bresp, rresp;
    logic [DW-1:0]  rdata;
    logic [NR*DW-1:0] reg_out, reg_in;
    logic [NR-1:0]  wr_pulse, rd_pulse;

    int total = 0;
    int bad   = 0;
    logic [1:0]  sb_b[$];
    logic [33:0] sb_r[$];
    logic [33:0] re;

    axi4l_regbank #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_REGS (NR),
        .RO_MASK    (16'h0008), .RST_VAL ('0)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .s_awaddr (awaddr), .s_awvalid (awvalid), .s_awready (awready),
        .s_wdata (wdata), .s_wstrb (wstrb), .s_wvalid (wvalid), .s_wready (wready),
        .s_bresp (bresp), .s_bvalid (bvalid), .s_bready (bready),
        .s_araddr (araddr), .s_arvalid (arvalid), .s_arready (arready),
        .s_rdata (rdata), .s_rresp (rresp), .s_rvalid (rvalid), .s_rready (rready),
        .reg_out (reg_out), .reg_in (reg_in),
        .wr_pulse (wr_pulse), .rd_pulse (rd_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; aw_at/w_at give the cycle each valid is raised.
    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] st,
                      input int aw_at, input int w_at, input logic [1:0] er,
                      input logic [NR-1:0] ep, input bit hold);
        bit aw_done, w_done, aw_hs, w_hs;
        int cyc;
        logic [1:0] e;
        sb_b.push_back(er);
        awaddr = a; wdata = d; wstrb = st;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            if (cyc == aw_at) awvalid = 1'b1;
            if (cyc == w_at)  wvalid  = 1'b1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); @(negedge clk);
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
            cyc++;
        end
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
        chk("bvalid", bvalid, 1'b1);
        e = sb_b.pop_front();
        chk("bresp", bresp, e);
        chk("wr_pulse", wr_pulse, ep);
        if (!hold) begin
            bready = 1'b1;
            @(negedge clk);
            bready = 1'b0;
            chk("bvalid_clr", bvalid, 1'b0);
            chk("wr_pulse_clr", wr_pulse, '0);
        end
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic [1:0] er,
                      input logic [NR-1:0] ep, input bit hold);
        int cyc;
        logic [33:0] e;
        sb_r.push_back({ed, er});
        araddr = a; arvalid = 1'b1; cyc = 0;
        while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
        chk("arready", arready, 1'b1);
        @(posedge clk); @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid", rvalid, 1'b1);
        e = sb_r.pop_front();
        chk("rdata", rdata, e[33:2]);
        chk("rresp", rresp, e[1:0]);
        chk("rd_pulse", rd_pulse, ep);
        if (!hold) begin
            rready = 1'b1;
            @(negedge clk);
            rready = 1'b0;
            chk("rvalid_clr", rvalid, 1'b0);
            chk("rd_pulse_clr", rd_pulse, '0);
        end
    endtask

    initial begin
        rst_n = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        for (int i = 0; i < NR; i++)
            reg_in[i*DW +: DW] = (i == 3) ? 32'hCAFE_0000 : 32'h5A5A_5A5A;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready",  wready,  1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid",  bvalid,  1'b0);
        chk("rst_rvalid",  rvalid,  1'b0);
        chk("rst_bresp",   bresp,   OKAY);
        chk("rst_rresp",   rresp,   OKAY);
        chk("rst_rdata",   rdata,   '0);
        chk("rst_wr_pulse", wr_pulse, '0);
        chk("rst_rd_pulse", rd_pulse, '0);
        chk("rst_reg0", reg_out[0 +: DW], '0);
        chk("rst_reg3_ro", reg_out[3*DW +: DW], 32'hCAFE_0000);
        rst_n = 1;
        @(negedge clk);

        // sweep every register after reset
        for (int i = 0; i < NR; i++)
            rd(AW'(i*4), (i == 3) ? 32'hCAFE_0000 : 32'h0, OKAY, NR'(1) << i, 0);

        // AW two cycles ahead of W, then read back (also with low addr bits set)
        wr(12'h008, 32'hDEAD_BEEF, 4'hF, 0, 2, OKAY, 16'h0004, 0);
        chk("reg_out2", reg_out[2*DW +: DW], 32'hDEAD_BEEF);
        rd(12'h008, 32'hDEAD_BEEF, OKAY, 16'h0004, 0);
        rd(12'h00B, 32'hDEAD_BEEF, OKAY, 16'h0004, 0);

        // byte strobes, W ahead of AW on the second write
        wr(12'h004, 32'hFFFF_FFFF, 4'hF, 0, 0, OKAY, 16'h0002, 0);
        wr(12'h004, 32'h1234_5678, 4'b0101, 1, 0, OKAY, 16'h0002, 0);
`ifdef AXI4L_REGBANK_WSTRB_EN
        rd(12'h004, 32'hFF34_FF78, OKAY, 16'h0002, 0);
`else
        rd(12'h004, 32'h1234_5678, OKAY, 16'h0002, 0);
`endif

        // read-only slot
        wr(12'h00C, 32'h0000_0001, 4'hF, 0, 0, SLVERR, '0, 0);
        rd(12'h00C, 32'hCAFE_0000, OKAY, 16'h0008, 0);

        // out-of-range decode, both far and just past the last register
        wr(12'h400, 32'h1111_1111, 4'hF, 0, 0, DECERR, '0, 0);
        rd(12'h400, 32'h0, DECERR, '0, 0);
        wr(12'h040, 32'h2222_2222, 4'hF, 0, 0, DECERR, '0, 0);
        rd(12'h040, 32'h0, DECERR, '0, 0);

        // last register
        wr(12'h03C, 32'h0F0F_0F0F, 4'hF, 0, 0, OKAY, 16'h8000, 0);
        rd(12'h03C, 32'h0F0F_0F0F, OKAY, 16'h8000, 0);

        // same-edge read accept and write commit on reg 2: read sees old value
        sb_r.push_back({32'hDEAD_BEEF, OKAY});
        sb_b.push_back(OKAY);
        awaddr = 12'h008; wdata = 32'h5555_AAAA; wstrb = 4'hF; araddr = 12'h008;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge clk); @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        re = sb_r.pop_front();
        chk("race_rdata", rdata, re[33:2]);
        chk("race_bresp", bresp, sb_b.pop_front());
        chk("race_pulses", {wr_pulse, rd_pulse}, {16'h0004, 16'h0004});
        bready = 1; rready = 1;
        @(negedge clk);
        bready = 0; rready = 0;
        rd(12'h008, 32'h5555_AAAA, OKAY, 16'h0004, 0);

        // backpressure on both channels, then reset during the hold
        wr(12'h014, 32'hA5A5_A5A5, 4'hF, 0, 0, OKAY, 16'h0020, 1);
        rd(12'h014, 32'hA5A5_A5A5, OKAY, 16'h0020, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_bvalid",  bvalid,  1'b1);
            chk("hold_bresp",   bresp,   OKAY);
            chk("hold_rvalid",  rvalid,  1'b1);
            chk("hold_rdata",   rdata,   32'hA5A5_A5A5);
            chk("hold_awready", awready, 1'b0);
            chk("hold_arready", arready, 1'b0);
        end
        rst_n = 0;
        @(negedge clk);
        chk("mid_rst_bvalid", bvalid, 1'b0);
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_rdata",  rdata,  '0);
        chk("mid_rst_reg5",   reg_out[5*DW +: DW], '0);
        chk("mid_rst_reg2",   reg_out[2*DW +: DW], '0);
        rst_n = 1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_bvalid", bvalid, 1'b0);
        chk("post_rst_rvalid", rvalid, 1'b0);
        chk("post_rst_awready", awready, 1'b1);
        rd(12'h014, 32'h0, OKAY, 16'h0020, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
